// File: rtl/uart_sample_frame_ctrl_if.sv
// Byte-in / sample-out bundle for uart_sample_frame_ctrl.
//   master : the side that delivers UART bytes and consumes samples/status
//   slave  : the frame controller itself
// Signals:
//   in_uart_ready     one byte on in_uart_frame per clock where high
//   in_uart_frame     received UART byte
//   out_sample        assembled sample {MSB,LSB}
//   out_sample_valid  1-clock pulse, out_sample/out_channel valid
//   out_channel       channel from header of current frame
//   out_frame_done    1-clock pulse, frame ended with good checksum
//   out_frame_error   1-clock pulse, frame aborted
//   out_err_code      00 timeout, 01 bad header, 10 bad length, 11 checksum
//   out_busy          high whenever the sequencer is not hunting for SYNC0
//   out_frame_cnt     good-frame count, wraps
interface uart_sample_frame_ctrl_if;
    logic        in_uart_ready;
    logic [7:0]  in_uart_frame;
    logic [15:0] out_sample;
    logic        out_sample_valid;
    logic [3:0]  out_channel;
    logic        out_frame_done;
    logic        out_frame_error;
    logic [1:0]  out_err_code;
    logic        out_busy;
    logic [15:0] out_frame_cnt;

    modport master (
        output in_uart_ready, in_uart_frame,
        input  out_sample, out_sample_valid, out_channel, out_frame_done,
               out_frame_error, out_err_code, out_busy, out_frame_cnt
    );

    modport slave (
        input  in_uart_ready, in_uart_frame,
        output out_sample, out_sample_valid, out_channel, out_frame_done,
               out_frame_error, out_err_code, out_busy, out_frame_cnt
    );
endinterface

// File: rtl/uart_sample_frame_ctrl.sv
// Sequencer between the UART byte receiver and the 16-bit sample path.
// Hunts for a two-byte sync word, parses header (channel) and length, then
// pairs LSB/MSB bytes into samples and finally checks an XOR checksum.
// An inter-byte timeout aborts a stalled frame so that a byte-phase slip
// recovers at the next sync word.
// Ports:
//   in_clk  clock
//   in_rst  synchronous active-high reset
//   bus     uart_sample_frame_ctrl_if.slave (byte input, sample/status out)
// All outputs are registered: a byte taken at edge t is reflected after t.
module uart_sample_frame_ctrl #(
    parameter int         MAX_SAMPLES    = 64,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] SYNC0          = 8'hA5,
    parameter logic [7:0] SYNC1          = 8'h5A
) (
    input  logic                     in_clk,
    input  logic                     in_rst,
    uart_sample_frame_ctrl_if.slave  bus
);
    localparam int            TW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    LMAX = 8'(MAX_SAMPLES);

    typedef enum logic [2:0] {HUNT0, HUNT1, HDR, LEN, LSB, MSB, CSUM} state_t;

    state_t        state;
    logic [7:0]    csum;
    logic [7:0]    lo;
    logic [7:0]    remaining;
    logic [TW-1:0] timer;

    logic [15:0]   sample;
    logic          sample_valid;
    logic [3:0]    channel;
    logic          frame_done;
    logic          frame_error;
    logic [1:0]    err_code;
    logic          busy;
    logic [15:0]   frame_cnt;

    wire [7:0] b = bus.in_uart_frame;

    // busy is updated alongside every state change so it stays a plain
    // register yet tracks "state != HUNT0" without lag relative to state.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state        <= HUNT0;
            csum         <= '0;
            lo           <= '0;
            remaining    <= '0;
            timer        <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            channel      <= '0;
            frame_done   <= 1'b0;
            frame_error  <= 1'b0;
            err_code     <= '0;
            busy         <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            sample_valid <= 1'b0;
            frame_done   <= 1'b0;
            frame_error  <= 1'b0;
            if (bus.in_uart_ready) begin
                // A byte in the expiry cycle takes priority over the timeout.
                timer <= '0;
                case (state)
                    HUNT0: if (b == SYNC0) begin
                        state <= HUNT1;
                        busy  <= 1'b1;
                    end
                    HUNT1: begin
                        if (b == SYNC1) begin
                            state <= HDR;
                        end else if (b != SYNC0) begin
                            state <= HUNT0;
                            busy  <= 1'b0;
                        end
                    end
                    HDR: begin
                        if (b[7:4] != 4'd0) begin
                            frame_error <= 1'b1;
                            err_code    <= 2'b01;
                            state       <= HUNT0;
                            busy        <= 1'b0;
                        end else begin
                            channel <= b[3:0];
                            csum    <= b;
                            state   <= LEN;
                        end
                    end
                    LEN: begin
                        if (b == 8'd0 || b > LMAX) begin
                            frame_error <= 1'b1;
                            err_code    <= 2'b10;
                            state       <= HUNT0;
                            busy        <= 1'b0;
                        end else begin
                            remaining <= b;
                            csum      <= csum ^ b;
                            state     <= LSB;
                        end
                    end
                    LSB: begin
                        lo    <= b;
                        csum  <= csum ^ b;
                        state <= MSB;
                    end
                    MSB: begin
                        sample       <= {b, lo};
                        sample_valid <= 1'b1;
                        csum         <= csum ^ b;
                        remaining    <= remaining - 8'd1;
                        state        <= (remaining == 8'd1) ? CSUM : LSB;
                    end
                    CSUM: begin
                        if (b == csum) begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 16'd1;
                        end else begin
                            frame_error <= 1'b1;
                            err_code    <= 2'b11;
                        end
                        state <= HUNT0;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= HUNT0;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (state == HUNT0) begin
                timer <= '0;
            end else if (timer == TMAX) begin
                // TIMEOUT_CYCLES idle clocks since the last accepted byte.
                timer       <= '0;
                frame_error <= 1'b1;
                err_code    <= 2'b00;
                state       <= HUNT0;
                busy        <= 1'b0;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

    assign bus.out_sample       = sample;
    assign bus.out_sample_valid = sample_valid;
    assign bus.out_channel      = channel;
    assign bus.out_frame_done   = frame_done;
    assign bus.out_frame_error  = frame_error;
    assign bus.out_err_code     = err_code;
    assign bus.out_busy         = busy;
    assign bus.out_frame_cnt    = frame_cnt;
endmodule

// File: tb/tb_uart_sample_frame_ctrl.sv
// Directed bench for uart_sample_frame_ctrl: a per-clock vector table for
// the byte-level frame cases, plus hand sequences for timeout and reset.
module tb_uart_sample_frame_ctrl;
    logic in_clk = 1'b0;
    logic in_rst = 1'b1;

    uart_sample_frame_ctrl_if bus();

    uart_sample_frame_ctrl #(
        .MAX_SAMPLES   (64),
        .TIMEOUT_CYCLES(50),
        .SYNC0         (8'hA5),
        .SYNC1         (8'h5A)
    ) dut (
        .in_clk(in_clk),
        .in_rst(in_rst),
        .bus   (bus.slave)
    );

    always #5 in_clk = ~in_clk;

    typedef struct packed {
        logic        vld;
        logic [15:0] sample;
        logic [3:0]  ch;
        logic        done;
        logic        err;
        logic [1:0]  code;
        logic        busy;
        logic [15:0] cnt;
    } outs_t;

    typedef struct {
        logic       rdy;
        logic [7:0] data;
        outs_t      exp;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    function automatic outs_t observe();
        outs_t o;
        o.vld    = bus.out_sample_valid;
        o.sample = bus.out_sample;
        o.ch     = bus.out_channel;
        o.done   = bus.out_frame_done;
        o.err    = bus.out_frame_error;
        o.code   = bus.out_err_code;
        o.busy   = bus.out_busy;
        o.cnt    = bus.out_frame_cnt;
        return o;
    endfunction

    // Expected values after the edge that consumes the row's byte.
    function automatic void add(input logic rdy, input logic [7:0] d,
                                input logic vld, input logic [15:0] s,
                                input logic [3:0] ch, input logic done,
                                input logic err, input logic [1:0] code,
                                input logic busy, input logic [15:0] cnt);
        vec_t v;
        v.rdy  = rdy;
        v.data = d;
        v.exp  = {vld, s, ch, done, err, code, busy, cnt};
        vecs.push_back(v);
    endfunction

    task automatic step(input logic rdy, input logic [7:0] d);
        bus.in_uart_ready = rdy;
        bus.in_uart_frame = d;
        @(posedge in_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d);
    endtask

    initial begin
        int early;
        int errs;
        bus.in_uart_ready = 1'b0;
        bus.in_uart_frame = 8'h00;

        // Test 1: two samples, good checksum (one idle clock mid-frame)
        add(1,8'hA5, 0,16'h0000,4'h0, 0,0,2'd0, 1,16'd0);
        add(1,8'h5A, 0,16'h0000,4'h0, 0,0,2'd0, 1,16'd0);
        add(1,8'h03, 0,16'h0000,4'h3, 0,0,2'd0, 1,16'd0);
        add(1,8'h02, 0,16'h0000,4'h3, 0,0,2'd0, 1,16'd0);
        add(1,8'h34, 0,16'h0000,4'h3, 0,0,2'd0, 1,16'd0);
        add(0,8'hFF, 0,16'h0000,4'h3, 0,0,2'd0, 1,16'd0);
        add(1,8'h12, 1,16'h1234,4'h3, 0,0,2'd0, 1,16'd0);
        add(1,8'h78, 0,16'h1234,4'h3, 0,0,2'd0, 1,16'd0);
        add(1,8'h56, 1,16'h5678,4'h3, 0,0,2'd0, 1,16'd0);
        add(1,8'h09, 0,16'h5678,4'h3, 1,0,2'd0, 0,16'd1);
        // Test 2: same frame, bad checksum
        add(1,8'hA5, 0,16'h5678,4'h3, 0,0,2'd0, 1,16'd1);
        add(1,8'h5A, 0,16'h5678,4'h3, 0,0,2'd0, 1,16'd1);
        add(1,8'h03, 0,16'h5678,4'h3, 0,0,2'd0, 1,16'd1);
        add(1,8'h02, 0,16'h5678,4'h3, 0,0,2'd0, 1,16'd1);
        add(1,8'h34, 0,16'h5678,4'h3, 0,0,2'd0, 1,16'd1);
        add(1,8'h12, 1,16'h1234,4'h3, 0,0,2'd0, 1,16'd1);
        add(1,8'h78, 0,16'h1234,4'h3, 0,0,2'd0, 1,16'd1);
        add(1,8'h56, 1,16'h5678,4'h3, 0,0,2'd0, 1,16'd1);
        add(1,8'h08, 0,16'h5678,4'h3, 0,1,2'd3, 0,16'd1);
        // Test 3: slip recovery, repeated SYNC0, single-sample frame
        add(1,8'h00, 0,16'h5678,4'h3, 0,0,2'd3, 0,16'd1);
        add(1,8'hA5, 0,16'h5678,4'h3, 0,0,2'd3, 1,16'd1);
        add(1,8'hA5, 0,16'h5678,4'h3, 0,0,2'd3, 1,16'd1);
        add(1,8'h5A, 0,16'h5678,4'h3, 0,0,2'd3, 1,16'd1);
        add(1,8'h01, 0,16'h5678,4'h1, 0,0,2'd3, 1,16'd1);
        add(1,8'h01, 0,16'h5678,4'h1, 0,0,2'd3, 1,16'd1);
        add(1,8'hCD, 0,16'h5678,4'h1, 0,0,2'd3, 1,16'd1);
        add(1,8'hAB, 1,16'hABCD,4'h1, 0,0,2'd3, 1,16'd1);
        add(1,8'h66, 0,16'hABCD,4'h1, 1,0,2'd3, 0,16'd2);
        // Test 4: length 0, length 65, good frame, bad header
        add(1,8'hA5, 0,16'hABCD,4'h1, 0,0,2'd3, 1,16'd2);
        add(1,8'h5A, 0,16'hABCD,4'h1, 0,0,2'd3, 1,16'd2);
        add(1,8'h00, 0,16'hABCD,4'h0, 0,0,2'd3, 1,16'd2);
        add(1,8'h00, 0,16'hABCD,4'h0, 0,1,2'd2, 0,16'd2);
        add(1,8'hA5, 0,16'hABCD,4'h0, 0,0,2'd2, 1,16'd2);
        add(1,8'h5A, 0,16'hABCD,4'h0, 0,0,2'd2, 1,16'd2);
        add(1,8'h00, 0,16'hABCD,4'h0, 0,0,2'd2, 1,16'd2);
        add(1,8'h41, 0,16'hABCD,4'h0, 0,1,2'd2, 0,16'd2);
        add(1,8'hA5, 0,16'hABCD,4'h0, 0,0,2'd2, 1,16'd2);
        add(1,8'h5A, 0,16'hABCD,4'h0, 0,0,2'd2, 1,16'd2);
        add(1,8'h03, 0,16'hABCD,4'h3, 0,0,2'd2, 1,16'd2);
        add(1,8'h02, 0,16'hABCD,4'h3, 0,0,2'd2, 1,16'd2);
        add(1,8'h34, 0,16'hABCD,4'h3, 0,0,2'd2, 1,16'd2);
        add(1,8'h12, 1,16'h1234,4'h3, 0,0,2'd2, 1,16'd2);
        add(1,8'h78, 0,16'h1234,4'h3, 0,0,2'd2, 1,16'd2);
        add(1,8'h56, 1,16'h5678,4'h3, 0,0,2'd2, 1,16'd2);
        add(1,8'h09, 0,16'h5678,4'h3, 1,0,2'd2, 0,16'd3);
        add(1,8'hA5, 0,16'h5678,4'h3, 0,0,2'd2, 1,16'd3);
        add(1,8'h5A, 0,16'h5678,4'h3, 0,0,2'd2, 1,16'd3);
        add(1,8'h10, 0,16'h5678,4'h3, 0,1,2'd1, 0,16'd3);

        // Reset: bytes during reset are ignored, outputs all zero
        step(1'b1, 8'hA5);
        step(1'b1, 8'h5A);
        in_rst = 1'b0;
        check("reset_state", 64'(observe()), 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rdy, vecs[i].data);
            check($sformatf("vec%0d", i), 64'(observe()), 64'(vecs[i].exp));
        end

        // Test 5a: silence after a data byte -> timeout on the 50th idle clock
        send(8'hA5); send(8'h5A); send(8'h03); send(8'h02); send(8'h34);
        early = 0;
        for (int k = 1; k < 50; k++) begin
            step(1'b0, 8'h00);
            if (bus.out_frame_error !== 1'b0 || bus.out_busy !== 1'b1) early++;
        end
        check("timeout_not_early", 64'(early), 64'd0);
        step(1'b0, 8'h00);
        check("timeout_pulse", {61'd0, bus.out_frame_error, bus.out_err_code},
              {61'd0, 1'b1, 2'b00});
        check("timeout_busy_cnt", {47'd0, bus.out_busy, bus.out_frame_cnt},
              {47'd0, 1'b0, 16'd3});
        step(1'b0, 8'h00);
        check("timeout_one_clock", 64'(bus.out_frame_error), 64'd0);

        // Test 5b: byte arrives in the expiry cycle and wins
        send(8'hA5); send(8'h5A); send(8'h03); send(8'h02); send(8'h34);
        for (int k = 1; k < 50; k++) step(1'b0, 8'h00);
        send(8'h12);
        check("expiry_byte_wins", {46'd0, bus.out_frame_error, bus.out_busy,
              bus.out_sample_valid, bus.out_sample},
              {46'd0, 1'b0, 1'b1, 1'b1, 16'h1234});
        send(8'h78); send(8'h56); send(8'h09);
        check("expiry_frame_done", {47'd0, bus.out_frame_done, bus.out_frame_cnt},
              {47'd0, 1'b1, 16'd4});

        // Test 6: reset mid-frame discards everything without an error pulse
        send(8'hA5); send(8'h5A); send(8'h03); send(8'h02); send(8'h34);
        in_rst = 1'b1;
        step(1'b1, 8'h12);
        check("midframe_reset", 64'(observe()), 64'd0);
        in_rst = 1'b0;
        errs = 0;
        send(8'hA5); if (bus.out_frame_error) errs++;
        send(8'h5A); if (bus.out_frame_error) errs++;
        send(8'h03); if (bus.out_frame_error) errs++;
        send(8'h02); if (bus.out_frame_error) errs++;
        send(8'h34); if (bus.out_frame_error) errs++;
        send(8'h12); if (bus.out_frame_error) errs++;
        send(8'h78); if (bus.out_frame_error) errs++;
        send(8'h56); if (bus.out_frame_error) errs++;
        send(8'h09); if (bus.out_frame_error) errs++;
        check("post_reset_done", {43'd0, bus.out_frame_done, bus.out_channel, bus.out_frame_cnt},
              {43'd0, 1'b1, 4'h3, 16'd1});
        check("post_reset_no_error", 64'(errs), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
